// File: rtl/camera_seq_pkg.sv
// Shared types for the camera frame sequencer.
//   seq_state_e  : FSM state encoding (3-bit)
//   FRAME_CNT_W  : width of the completed-frame counter
package camera_seq_pkg;

  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_WAIT_SOF = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5,
    S_ABORT    = 3'd6
  } seq_state_e;

endpackage

// File: rtl/camera_frame_sequencer.sv
// Frame-level controller for the parallel camera RX path.
// Arms the uDMA RX channel per frame, gates the camera datapath from
// start-of-frame to transfer completion, ping-pongs between two L2 buffers
// and handles overrun and software disable.
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   cfg_*                  : enable, buffer addresses, frame size, frame count
//   frame_start_i          : start-of-frame pulse from camera datapath
//   rx_en_i                : uDMA RX channel busy
//   rx_startaddr_o/size_o  : channel programming, held between arms
//   rx_en_o / rx_clr_o     : one-cycle channel arm / clear pulses
//   cam_en_o               : camera datapath data enable
//   buf_sel_o, frame_cnt_o : current buffer, completed frames since enable
//   *_evt_o                : one-cycle event pulses
//   busy_o                 : FSM not idle
// All outputs are registered; they are computed from the next state.
module camera_frame_sequencer
  import camera_seq_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_seq_en_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf0_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_buf1_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_frame_size_i,
  input  logic [FRAME_CNT_W-1:0]    cfg_nframes_i,
  input  logic                      frame_start_i,
  input  logic                      rx_en_i,
  output logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     rx_size_o,
  output logic                      rx_en_o,
  output logic                      rx_clr_o,
  output logic                      cam_en_o,
  output logic                      buf_sel_o,
  output logic [FRAME_CNT_W-1:0]    frame_cnt_o,
  output logic                      frame_done_evt_o,
  output logic                      seq_done_evt_o,
  output logic                      overrun_evt_o,
  output logic                      busy_o
);

  seq_state_e                state_q, state_d;
  logic [FRAME_CNT_W-1:0]    nframes_q, nframes_d;
  logic [FRAME_CNT_W-1:0]    cnt_d;
  logic                      buf_d;
  logic [L2_AWIDTH_NOAL-1:0] addr_d;
  logic [TRANS_SIZE-1:0]     size_d;
  logic                      ovr_d, clr_d, seq_d;

  always_comb begin
    state_d = state_q;
    ovr_d   = 1'b0;
    clr_d   = 1'b0;

    unique case (state_q)
      S_IDLE:     if (cfg_seq_en_i) state_d = S_ARM;
      S_ARM:      state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (rx_en_i) state_d = S_WAIT_SOF;
      S_WAIT_SOF: if (frame_start_i) state_d = S_CAPTURE;
      S_CAPTURE: begin
        // A channel-idle seen together with SOF counts as completion.
        if (!rx_en_i) begin
          state_d = S_DONE;
        end else if (frame_start_i) begin
          state_d = S_ABORT;
          ovr_d   = 1'b1;
        end
      end
      S_DONE:     state_d = seq_done_evt_o ? S_IDLE : S_ARM;
      S_ABORT:    if (!rx_en_i) state_d = S_ARM;
      default:    state_d = S_IDLE;
    endcase

    // Disable overrides every other transition.
    if (!cfg_seq_en_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ovr_d   = 1'b0;
      clr_d   = (state_q != S_DONE) || rx_en_i;
    end
    clr_d = clr_d | ovr_d;

    cnt_d = frame_cnt_o;
    buf_d = buf_sel_o;
    if (state_q == S_IDLE && state_d == S_ARM) begin
      cnt_d = '0;
      buf_d = 1'b0;
    end else if (state_d == S_DONE) begin
      cnt_d = frame_cnt_o + 1'b1;
      buf_d = ~buf_sel_o;
    end

    // Configuration is captured only on entry to ARM.
    nframes_d = nframes_q;
    addr_d    = rx_startaddr_o;
    size_d    = rx_size_o;
    if (state_d == S_ARM) begin
      nframes_d = cfg_nframes_i;
      addr_d    = buf_d ? cfg_buf1_addr_i : cfg_buf0_addr_i;
      size_d    = cfg_frame_size_i;
    end

    seq_d = (state_d == S_DONE) && (nframes_q != '0) && (cnt_d == nframes_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= S_IDLE;
      nframes_q        <= '0;
      rx_startaddr_o   <= '0;
      rx_size_o        <= '0;
      rx_en_o          <= 1'b0;
      rx_clr_o         <= 1'b0;
      cam_en_o         <= 1'b0;
      buf_sel_o        <= 1'b0;
      frame_cnt_o      <= '0;
      frame_done_evt_o <= 1'b0;
      seq_done_evt_o   <= 1'b0;
      overrun_evt_o    <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      state_q          <= state_d;
      nframes_q        <= nframes_d;
      rx_startaddr_o   <= addr_d;
      rx_size_o        <= size_d;
      rx_en_o          <= (state_d == S_ARM);
      rx_clr_o         <= clr_d;
      cam_en_o         <= (state_d == S_CAPTURE);
      buf_sel_o        <= buf_d;
      frame_cnt_o      <= cnt_d;
      frame_done_evt_o <= (state_d == S_DONE);
      seq_done_evt_o   <= seq_d;
      overrun_evt_o    <= ovr_d;
      busy_o           <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_camera_frame_sequencer.sv
// Directed self-checking bench for camera_frame_sequencer.
module tb_camera_frame_sequencer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cfg_seq_en_i;
  logic [11:0] cfg_buf0_addr_i;
  logic [11:0] cfg_buf1_addr_i;
  logic [15:0] cfg_frame_size_i;
  logic [7:0]  cfg_nframes_i;
  logic        frame_start_i;
  logic        rx_en_i;
  logic [11:0] rx_startaddr_o;
  logic [15:0] rx_size_o;
  logic        rx_en_o, rx_clr_o, cam_en_o, buf_sel_o;
  logic [7:0]  frame_cnt_o;
  logic        frame_done_evt_o, seq_done_evt_o, overrun_evt_o, busy_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  camera_frame_sequencer #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_seq_en_i(cfg_seq_en_i),
    .cfg_buf0_addr_i(cfg_buf0_addr_i), .cfg_buf1_addr_i(cfg_buf1_addr_i),
    .cfg_frame_size_i(cfg_frame_size_i), .cfg_nframes_i(cfg_nframes_i),
    .frame_start_i(frame_start_i), .rx_en_i(rx_en_i),
    .rx_startaddr_o(rx_startaddr_o), .rx_size_o(rx_size_o),
    .rx_en_o(rx_en_o), .rx_clr_o(rx_clr_o), .cam_en_o(cam_en_o),
    .buf_sel_o(buf_sel_o), .frame_cnt_o(frame_cnt_o),
    .frame_done_evt_o(frame_done_evt_o), .seq_done_evt_o(seq_done_evt_o),
    .overrun_evt_o(overrun_evt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one active edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    logic [31:0] v;
    v = {rx_startaddr_o, rx_size_o, rx_en_o, rx_clr_o};
    chk({tag, "_addr_size_en_clr"}, v, 32'h0);
    v = {19'd0, cam_en_o, buf_sel_o, frame_cnt_o, frame_done_evt_o,
         seq_done_evt_o, overrun_evt_o, busy_o};
    chk({tag, "_misc"}, v, 32'h0);
  endtask

  // Entered just after the edge into ARM; leaves just after the edge out of DONE.
  task automatic run_frame(input logic [11:0] exp_addr, input logic [7:0] exp_cnt,
                           input logic exp_seq, input logic exp_buf_after);
    chk("arm_rx_en", {31'd0, rx_en_o}, 32'd1);
    chk("arm_addr", {20'd0, rx_startaddr_o}, {20'd0, exp_addr});
    rx_en_i = 1'b1;
    step();                                   // WAIT_ACK
    chk("ack_rx_en_low", {31'd0, rx_en_o}, 32'd0);
    step();                                   // WAIT_SOF
    frame_start_i = 1'b1;
    step();                                   // CAPTURE
    frame_start_i = 1'b0;
    chk("cap_cam_en", {31'd0, cam_en_o}, 32'd1);
    rx_en_i = 1'b0;
    step();                                   // DONE
    chk("done_cam_en", {31'd0, cam_en_o}, 32'd0);
    chk("done_evt", {31'd0, frame_done_evt_o}, 32'd1);
    chk("done_cnt", {24'd0, frame_cnt_o}, {24'd0, exp_cnt});
    chk("done_seq", {31'd0, seq_done_evt_o}, {31'd0, exp_seq});
    chk("done_buf", {31'd0, buf_sel_o}, {31'd0, exp_buf_after});
    step();
    chk("post_done_evt", {31'd0, frame_done_evt_o}, 32'd0);
  endtask

  initial begin
    rstn_i = 1'b0; cfg_seq_en_i = 1'b0; frame_start_i = 1'b0; rx_en_i = 1'b0;
    cfg_buf0_addr_i = 12'h100; cfg_buf1_addr_i = 12'h200;
    cfg_frame_size_i = 16'h0040; cfg_nframes_i = 8'd2;
    repeat (3) step();
    chk_all_zero("reset");
    rstn_i = 1'b1;
    step();
    chk_all_zero("idle");

    // Two-frame sequence.
    cfg_seq_en_i = 1'b1;
    step();
    chk("arm_size", {16'd0, rx_size_o}, 32'h40);
    chk("arm_busy", {31'd0, busy_o}, 32'd1);
    run_frame(12'h100, 8'd1, 1'b0, 1'b1);
    run_frame(12'h200, 8'd2, 1'b1, 1'b0);
    chk("seq_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("seq_idle_cnt", {24'd0, frame_cnt_o}, 32'd2);
    chk("seq_idle_seq_evt", {31'd0, seq_done_evt_o}, 32'd0);
    cfg_seq_en_i = 1'b0;
    step();
    chk("stay_idle_rx_en", {31'd0, rx_en_o}, 32'd0);

    // Continuous mode, 257 frames: counter wraps, buffers alternate.
    cfg_nframes_i = 8'd0;
    cfg_seq_en_i = 1'b1;
    step();
    for (int i = 1; i <= 257; i++) begin
      logic [7:0] c;
      c = 8'(i);
      run_frame((i % 2 == 1) ? 12'h100 : 12'h200, c, 1'b0, (i % 2 == 1));
    end
    chk("wrap_cnt", {24'd0, frame_cnt_o}, 32'd1);
    chk("wrap_arm_addr", {20'd0, rx_startaddr_o}, 32'h200);
    cfg_seq_en_i = 1'b0;
    step();
    chk("dis_arm_clr", {31'd0, rx_clr_o}, 32'd1);
    chk("dis_arm_busy", {31'd0, busy_o}, 32'd0);
    step();
    chk("dis_clr_pulse", {31'd0, rx_clr_o}, 32'd0);

    // Overrun.
    cfg_seq_en_i = 1'b1;
    step();
    chk("ovr_arm_addr", {20'd0, rx_startaddr_o}, 32'h100);
    chk("ovr_arm_cnt", {24'd0, frame_cnt_o}, 32'd0);
    rx_en_i = 1'b1;
    step(); step();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    step();
    chk("ovr_cap_cam", {31'd0, cam_en_o}, 32'd1);
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    chk("ovr_evt", {31'd0, overrun_evt_o}, 32'd1);
    chk("ovr_clr", {31'd0, rx_clr_o}, 32'd1);
    chk("ovr_cam_off", {31'd0, cam_en_o}, 32'd0);
    chk("ovr_cnt", {24'd0, frame_cnt_o}, 32'd0);
    step();
    chk("ovr_evt_pulse", {31'd0, overrun_evt_o}, 32'd0);
    chk("ovr_clr_pulse", {31'd0, rx_clr_o}, 32'd0);
    rx_en_i = 1'b0;
    step();
    run_frame(12'h100, 8'd1, 1'b0, 1'b1);

    // SOF coincident with channel going idle: completion, not overrun.
    rx_en_i = 1'b1;
    step(); step();
    frame_start_i = 1'b1;
    step();
    rx_en_i = 1'b0;
    step();
    frame_start_i = 1'b0;
    chk("coinc_done", {31'd0, frame_done_evt_o}, 32'd1);
    chk("coinc_no_ovr", {31'd0, overrun_evt_o}, 32'd0);
    chk("coinc_cnt", {24'd0, frame_cnt_o}, 32'd2);
    step();
    chk("coinc_rearm_addr", {20'd0, rx_startaddr_o}, 32'h100);

    // Disable together with SOF in WAIT_SOF.
    rx_en_i = 1'b1;
    step(); step();
    frame_start_i = 1'b1;
    cfg_seq_en_i = 1'b0;
    step();
    frame_start_i = 1'b0;
    rx_en_i = 1'b0;
    chk("dsof_clr", {31'd0, rx_clr_o}, 32'd1);
    chk("dsof_cam", {31'd0, cam_en_o}, 32'd0);
    chk("dsof_busy", {31'd0, busy_o}, 32'd0);
    step();
    chk("dsof_cam_later", {31'd0, cam_en_o}, 32'd0);

    // SOF during WAIT_ACK is ignored.
    cfg_seq_en_i = 1'b1;
    step();
    frame_start_i = 1'b1;
    step();                                   // WAIT_ACK
    step();                                   // still WAIT_ACK
    chk("ack_sof_cam", {31'd0, cam_en_o}, 32'd0);
    rx_en_i = 1'b1;
    step();                                   // WAIT_SOF, SOF ignored
    frame_start_i = 1'b0;
    chk("ack_sof_cam2", {31'd0, cam_en_o}, 32'd0);
    step();
    chk("ack_sof_cam3", {31'd0, cam_en_o}, 32'd0);
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    chk("ack_then_cap", {31'd0, cam_en_o}, 32'd1);

    // Asynchronous reset during CAPTURE.
    #2;
    rstn_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk_i);
    rstn_i = 1'b1;
    rx_en_i = 1'b0;
    step();
    chk("rst_rearm", {31'd0, rx_en_o}, 32'd1);
    chk("rst_rearm_addr", {20'd0, rx_startaddr_o}, 32'h100);
    chk("rst_rearm_buf", {31'd0, buf_sel_o}, 32'd0);
    chk("rst_rearm_cnt", {24'd0, frame_cnt_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/camera_frame_sequencer.md
# camera_frame_sequencer

Frame-level controller for the parallel camera RX path. Sequences the uDMA RX channel frame by frame: programs start address and size, arms the channel, and gates the camera interface from start-of-frame to transfer completion. Alternates between two L2 buffers (ping-pong) and handles overrun and software abort. Sits between the camera register interface and the uDMA RX channel/camera datapath.

## Interface
- L2_AWIDTH_NOAL, 12, L2 address width of RX buffers
- TRANS_SIZE, 16, width of RX transfer size in bytes
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_seq_en_i  in  1  sequencer enable (level); low aborts and idles
- cfg_buf0_addr_i  in  L2_AWIDTH_NOAL  buffer 0 start address
- cfg_buf1_addr_i  in  L2_AWIDTH_NOAL  buffer 1 start address
- cfg_frame_size_i  in  TRANS_SIZE  bytes per frame
- cfg_nframes_i  in  8  frames to capture; 0 = continuous
- frame_start_i  in  1  single-cycle start-of-frame pulse from camera datapath
- rx_en_i  in  1  uDMA RX channel busy
- rx_startaddr_o  out  L2_AWIDTH_NOAL  channel start address
- rx_size_o  out  TRANS_SIZE  channel transfer size
- rx_en_o  out  1  one-cycle channel arm pulse
- rx_clr_o  out  1  one-cycle channel clear pulse
- cam_en_o  out  1  camera datapath data enable
- buf_sel_o  out  1  buffer currently targeted
- frame_cnt_o  out  8  completed frames since enable
- frame_done_evt_o  out  1  one-cycle pulse per completed frame
- seq_done_evt_o  out  1  one-cycle pulse when cfg_nframes_i frames have completed
- overrun_evt_o  out  1  one-cycle pulse on overrun
- busy_o  out  1  FSM not IDLE

## Operation
- States: IDLE, ARM, WAIT_ACK, WAIT_SOF, CAPTURE, DONE, ABORT.
- IDLE: when cfg_seq_en_i=1 -> ARM; clear frame_cnt, buf_sel=0.
- ARM (one cycle): load rx_startaddr_o from cfg_buf<buf_sel>_addr_i and rx_size_o from cfg_frame_size_i; assert rx_en_o; -> WAIT_ACK. Configuration inputs are sampled only here.
- WAIT_ACK: when rx_en_i=1 -> WAIT_SOF. frame_start_i is ignored.
- WAIT_SOF: on frame_start_i -> CAPTURE.
- CAPTURE: cam_en_o=1. When rx_en_i=0 -> DONE. If frame_start_i occurs first -> overrun: pulse overrun_evt_o and rx_clr_o, drop cam_en_o, -> ABORT.
- DONE (one cycle): pulse frame_done_evt_o, increment frame_cnt (8-bit wrap 255->0), toggle buf_sel. If cfg_nframes_i!=0 and the new count equals cfg_nframes_i, pulse seq_done_evt_o and -> IDLE; otherwise -> ARM.
- ABORT: when rx_en_i=0 -> ARM with the same buf_sel. frame_cnt is unchanged.
- Disable: cfg_seq_en_i=0 in any non-IDLE state pulses rx_clr_o (unless already in IDLE/DONE with channel idle) and -> IDLE. Disable has priority over every other transition, including a simultaneous frame_start_i or rx_en_i fall.
- rx_en_i fall coincident with frame_start_i in CAPTURE is a completion, not an overrun.

## Timing
- All outputs are registered. Reset values: all 0; rx_startaddr_o and rx_size_o are 0.
- Enable high at edge N: ARM during cycle N+1, with rx_en_o high for exactly that cycle. rx_startaddr_o and rx_size_o are valid in the same cycle and are held until the next ARM.
- frame_start_i at edge N in WAIT_SOF: cam_en_o high from cycle N+1.
- rx_en_i low at edge N in CAPTURE: cam_en_o low and frame_done_evt_o high in cycle N+1; rx_en_o re-armed in cycle N+2.
- Event outputs are exactly one cycle wide and never coincide with reset.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The channel is not cleared by this block.

## Structure
- Package camera_seq_pkg: state enum type (3-bit), frame counter width constant (8).
- Single module; no sub-module. Counter and FSM live inline.

## Test plan
- Enable with nframes=2, buf0=0x100, buf1=0x200, size=0x40; SOF, then rx_en_i drop, twice -> rx_en_o pulses with addr 0x100 then 0x200, frame_done twice, seq_done once, busy_o=0, frame_cnt_o=2.
- nframes=0, 257 frames -> frame_cnt_o wraps to 1, no seq_done_evt_o, buffers alternate throughout.
- SOF during CAPTURE before rx_en_i drops -> overrun_evt_o and rx_clr_o pulse. Next arm uses the same address. frame_cnt unchanged.
- Drop cfg_seq_en_i in the same cycle as frame_start_i in WAIT_SOF -> IDLE, rx_clr_o pulse, cam_en_o never rises.
- frame_start_i during WAIT_ACK -> ignored. Capture starts only on the next SOF after rx_en_i=1.
- Assert rstn_i low during CAPTURE -> all outputs 0 asynchronously. After release, the FSM restarts from ARM with buf 0.
